// File: rtl/alu_operand_loader_if.sv
// Board-side bundle for the ALU operand loader: raw switches/button in,
// captured operands, opcode and load status out.
interface alu_operand_loader_if #(
  parameter int n = 4
);
  logic [n-1:0] interruptores;
  logic         boton;
  logic [n-1:0] entrada1;
  logic [n-1:0] entrada2;
  logic [3:0]   selector;
  logic [1:0]   etapa;
  logic         listo;
  logic         valido;

  modport master (
    output interruptores, boton,
    input  entrada1, entrada2, selector, etapa, listo, valido
  );

  modport slave (
    input  interruptores, boton,
    output entrada1, entrada2, selector, etapa, listo, valido
  );
endinterface

// File: rtl/alu_operand_loader.sv
// Loads ALU operand A, operand B and opcode from board switches, one field per
// debounced button press, cycling A -> B -> OP -> LISTO -> A.
module alu_operand_loader #(
  parameter int n        = 4,
  parameter int DEBOUNCE = 500000
) (
  input  logic                 clock,
  input  logic                 reset,
  alu_operand_loader_if.slave  bus
);

  localparam int CW = $clog2(DEBOUNCE);

  typedef enum logic [1:0] {
    CARGA_A  = 2'd0,
    CARGA_B  = 2'd1,
    CARGA_OP = 2'd2,
    LISTO    = 2'd3
  } state_t;

  logic [n-1:0]  sw_s1_q, sw_s2_q;
  logic          btn_s1_q, btn_s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          deb_q, deb_d;
  logic          deb_dly_q;
  logic          press;

  state_t        state_q;
  logic [n-1:0]  a_q, b_q;
  logic [3:0]    op_q;
  logic          listo_q, valido_q;

  // Counter runs only while the synchronized button disagrees with the
  // debounced level; the DEBOUNCE-th disagreeing cycle flips the level.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (btn_s2_q != deb_q) begin
      if (cnt_q == CW'(DEBOUNCE - 1)) deb_d = ~deb_q;
      else                            cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      btn_s1_q  <= 1'b0;
      btn_s2_q  <= 1'b0;
      cnt_q     <= '0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
    end else begin
      sw_s1_q   <= bus.interruptores;
      sw_s2_q   <= sw_s1_q;
      btn_s1_q  <= bus.boton;
      btn_s2_q  <= btn_s1_q;
      cnt_q     <= cnt_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
    end
  end

  // Rising debounced level only; releases are ignored.
  assign press = deb_q & ~deb_dly_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= CARGA_A;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      listo_q  <= 1'b0;
      valido_q <= 1'b0;
    end else begin
      valido_q <= 1'b0;
      listo_q  <= (state_q == LISTO);
      if (press) begin
        case (state_q)
          CARGA_A: begin
            a_q     <= sw_s2_q;
            state_q <= CARGA_B;
          end
          CARGA_B: begin
            b_q     <= sw_s2_q;
            state_q <= CARGA_OP;
          end
          CARGA_OP: begin
            op_q     <= sw_s2_q[3:0];
            valido_q <= 1'b1;
            state_q  <= LISTO;
          end
          default: state_q <= CARGA_A;
        endcase
      end
    end
  end

  assign bus.entrada1 = a_q;
  assign bus.entrada2 = b_q;
  assign bus.selector = op_q;
  assign bus.etapa    = state_q;
  assign bus.listo    = listo_q;
  assign bus.valido   = valido_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench for alu_operand_loader: directed scenarios plus random
// button/switch traffic against a sample-history reference model.
module tb_alu_operand_loader;
  localparam int N  = 4;
  localparam int D  = 4;
  localparam int VW = 2 * N + 8;

  logic clock = 1'b0;
  logic reset = 1'b0;

  alu_operand_loader_if #(.n(N)) bus ();

  alu_operand_loader #(.n(N), .DEBOUNCE(D)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int valido_seen = 0;

  // Reference model: the debounced level flips once the last D synchronized
  // samples all disagree with it and at least D cycles passed since the last flip.
  logic         bh[$];
  logic [N-1:0] sh[$];
  logic         m_deb, m_press_pend;
  int           edge_n = 0, flip_edge;
  logic [1:0]   m_st;
  logic [N-1:0] m_a, m_b;
  logic [3:0]   m_op;
  logic         m_listo, m_valido;

  task automatic model_reset();
    bh.delete();
    sh.delete();
    for (int i = 0; i < D + 2; i++) begin
      bh.push_back(1'b0);
      sh.push_back('0);
    end
    m_deb = 0; m_press_pend = 0; flip_edge = -1000;
    m_st = 0; m_a = 0; m_b = 0; m_op = 0; m_listo = 0; m_valido = 0;
  endtask

  task automatic model_edge();
    logic press, all_diff;
    logic [N-1:0] swc;
    press    = m_press_pend;
    swc      = sh[1];
    m_listo  = (m_st == 2'd3);
    m_valido = press && (m_st == 2'd2);
    if (press) begin
      case (m_st)
        2'd0: m_a = swc;
        2'd1: m_b = swc;
        2'd2: m_op = swc[3:0];
        default: ;
      endcase
      m_st = m_st + 2'd1;
    end
    all_diff = 1'b1;
    for (int i = 1; i <= D; i++) if (bh[i] == m_deb) all_diff = 1'b0;
    m_press_pend = 1'b0;
    if (all_diff && (edge_n - flip_edge >= D)) begin
      m_deb        = ~m_deb;
      flip_edge    = edge_n;
      m_press_pend = m_deb;
    end
    bh.push_front(bus.boton);
    sh.push_front(bus.interruptores);
    void'(bh.pop_back());
    void'(sh.pop_back());
    edge_n++;
  endtask

  function automatic logic [VW-1:0] dut_vec();
    return {bus.etapa, bus.entrada1, bus.entrada2, bus.selector, bus.listo, bus.valido};
  endfunction

  function automatic logic [VW-1:0] model_vec();
    return {m_st, m_a, m_b, m_op, m_listo, m_valido};
  endfunction

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    if (bus.valido === 1'b1) valido_seen++;
  endtask

  task automatic drive(input logic b, input logic [N-1:0] sw, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      bus.boton = b;
      bus.interruptores = sw;
      tick();
    end
  endtask

  task automatic press(input logic [N-1:0] sw);
    drive(1'b1, sw, D + 4);
    drive(1'b0, sw, D + 4);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    valido_seen = 0;
  endtask

  task automatic test_reset();
    bus.boton = 1'b0;
    bus.interruptores = '0;
    reset = 1'b1;
    model_reset();
    #2;
    checks++; if (bus.etapa !== 2'd0)    begin errors++; $display("FAIL reset_etapa got %h exp 0", bus.etapa); end
    checks++; if (bus.entrada1 !== '0)   begin errors++; $display("FAIL reset_entrada1 got %h exp 0", bus.entrada1); end
    checks++; if (bus.entrada2 !== '0)   begin errors++; $display("FAIL reset_entrada2 got %h exp 0", bus.entrada2); end
    checks++; if (bus.selector !== 4'd0) begin errors++; $display("FAIL reset_selector got %h exp 0", bus.selector); end
    checks++; if (bus.listo !== 1'b0)    begin errors++; $display("FAIL reset_listo got %b exp 0", bus.listo); end
    checks++; if (bus.valido !== 1'b0)   begin errors++; $display("FAIL reset_valido got %b exp 0", bus.valido); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_full_load();
    int vcyc, lcyc;
    do_reset();
    press(N'(5));
    press(N'(3));
    vcyc = -1; lcyc = -1;
    for (int k = 0; k < D + 4; k++) begin
      bus.boton = 1'b1; bus.interruptores = N'(2);
      tick();
      if (vcyc < 0 && bus.valido === 1'b1) vcyc = k;
      if (lcyc < 0 && bus.listo === 1'b1) lcyc = k;
    end
    drive(1'b0, N'(2), D + 4);
    checks++; if (bus.entrada1 !== N'(5)) begin errors++; $display("FAIL load_entrada1 got %h exp 5", bus.entrada1); end
    checks++; if (bus.entrada2 !== N'(3)) begin errors++; $display("FAIL load_entrada2 got %h exp 3", bus.entrada2); end
    checks++; if (bus.selector !== 4'd2)  begin errors++; $display("FAIL load_selector got %h exp 2", bus.selector); end
    checks++; if (bus.listo !== 1'b1)     begin errors++; $display("FAIL load_listo got %b exp 1", bus.listo); end
    checks++; if (bus.etapa !== 2'd3)     begin errors++; $display("FAIL load_etapa got %0d exp 3", bus.etapa); end
    checks++; if (valido_seen != 1)       begin errors++; $display("FAIL load_valido_count got %0d exp 1", valido_seen); end
    checks++; if (vcyc < 0 || lcyc != vcyc + 1) begin errors++; $display("FAIL load_listo_timing valido@%0d listo@%0d exp listo one after valido", vcyc, lcyc); end
    checks++; if (dut_vec() !== model_vec()) begin errors++; $display("FAIL load_model got %h exp %h", dut_vec(), model_vec()); end
  endtask

  task automatic test_latency();
    int got;
    do_reset();
    got = -1;
    for (int k = 0; k < 40; k++) begin
      bus.boton = 1'b1; bus.interruptores = N'(9);
      tick();
      if (got < 0 && bus.etapa === 2'd1) got = k;
    end
    checks++; if (got != 2 + D) begin errors++; $display("FAIL latency got %0d exp %0d", got, 2 + D); end
    checks++; if (bus.entrada1 !== N'(9)) begin errors++; $display("FAIL latency_entrada1 got %h exp 9", bus.entrada1); end
    drive(1'b0, N'(9), D + 4);
  endtask

  task automatic test_bounce();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      bus.boton = ((i / 2) % 2) == 0;
      bus.interruptores = N'(15);
      tick();
    end
    drive(1'b0, N'(15), 10);
    checks++; if (bus.etapa !== 2'd0)   begin errors++; $display("FAIL bounce_etapa got %0d exp 0", bus.etapa); end
    checks++; if (bus.entrada1 !== '0)  begin errors++; $display("FAIL bounce_entrada1 got %h exp 0", bus.entrada1); end
    checks++; if (dut_vec() !== model_vec()) begin errors++; $display("FAIL bounce_model got %h exp %h", dut_vec(), model_vec()); end
  endtask

  task automatic test_hold();
    do_reset();
    drive(1'b1, N'(6), 100);
    checks++; if (bus.etapa !== 2'd1)     begin errors++; $display("FAIL hold_etapa got %0d exp 1", bus.etapa); end
    checks++; if (bus.entrada1 !== N'(6)) begin errors++; $display("FAIL hold_entrada1 got %h exp 6", bus.entrada1); end
    drive(1'b0, N'(6), D + 4);
  endtask

  task automatic test_wrap();
    do_reset();
    press(N'(5)); press(N'(3)); press(N'(2));
    press(N'(10));
    checks++; if (bus.etapa !== 2'd0)     begin errors++; $display("FAIL wrap_etapa got %0d exp 0", bus.etapa); end
    checks++; if (bus.entrada1 !== N'(5)) begin errors++; $display("FAIL wrap_entrada1_hold got %h exp 5", bus.entrada1); end
    checks++; if (bus.listo !== 1'b0)     begin errors++; $display("FAIL wrap_listo got %b exp 0", bus.listo); end
    checks++; if (bus.selector !== 4'd2)  begin errors++; $display("FAIL wrap_selector_hold got %h exp 2", bus.selector); end
    press(N'(10));
    checks++; if (bus.entrada1 !== N'(10)) begin errors++; $display("FAIL wrap_reload got %h exp a", bus.entrada1); end
    checks++; if (bus.entrada2 !== N'(3))  begin errors++; $display("FAIL wrap_entrada2_hold got %h exp 3", bus.entrada2); end
  endtask

  task automatic test_reset_mid();
    int got;
    do_reset();
    press(N'(7)); press(N'(1));
    checks++; if (bus.etapa !== 2'd2) begin errors++; $display("FAIL mid_pre_etapa got %0d exp 2", bus.etapa); end
    drive(1'b1, N'(4), 3);
    reset = 1'b1;
    model_reset();
    #1;
    checks++; if (dut_vec() !== '0) begin errors++; $display("FAIL mid_async_clear got %h exp 0", dut_vec()); end
    @(negedge clock);
    reset = 1'b0;
    got = -1;
    for (int k = 0; k < 40; k++) begin
      bus.boton = 1'b1; bus.interruptores = N'(4);
      tick();
      if (got < 0 && bus.etapa === 2'd1) got = k;
    end
    checks++; if (got != 2 + D) begin errors++; $display("FAIL mid_fresh_press got %0d exp %0d", got, 2 + D); end
    checks++; if (bus.entrada1 !== N'(4)) begin errors++; $display("FAIL mid_entrada1 got %h exp 4", bus.entrada1); end
    drive(1'b0, N'(4), D + 4);
  endtask

  task automatic test_random();
    logic b;
    int len;
    do_reset();
    for (int seg = 0; seg < 120; seg++) begin
      b   = $urandom_range(1, 0);
      len = $urandom_range(2 * D + 2, 1);
      for (int i = 0; i < len; i++) begin
        bus.boton = b;
        bus.interruptores = N'($urandom);
        tick();
        checks++;
        if (dut_vec() !== model_vec()) begin
          errors++;
          $display("FAIL random_cycle seg %0d got %h exp %h", seg, dut_vec(), model_vec());
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_load();
    test_latency();
    test_bounce();
    test_hold();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
